// File: rtl/sprite_anim_seq_if.sv
// sprite_anim_seq_if: per-frame keycode inputs and sprite-select outputs of the animation sequencer.
interface sprite_anim_seq_if #(
    parameter int WALK_FRAMES = 3
);
    localparam int FRAME_W = $clog2(WALK_FRAMES + 3);
    logic               frame_tick;
    logic [7:0]         keycode;
    logic [7:0]         keycode2;
    logic               airborne;
    logic [FRAME_W-1:0] frame_idx;
    logic               facing_left;
    logic               step_pulse;
    modport master (
        output frame_tick, keycode, keycode2, airborne,
        input  frame_idx, facing_left, step_pulse
    );
    modport slave (
        input  frame_tick, keycode, keycode2, airborne,
        output frame_idx, facing_left, step_pulse
    );
endinterface

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: per-frame stand/walk/skid/jump sequencer producing a registered sprite frame index,
// facing direction and footstep pulse from two keycode slots and the airborne flag.
module sprite_anim_seq #(
    parameter int         WALK_FRAMES = 3,
    parameter int         HOLD_TICKS  = 4,
    parameter int         SKID_TICKS  = 6,
    parameter logic [7:0] KEY_LEFT    = 8'h04,
    parameter logic [7:0] KEY_RIGHT   = 8'h07,
    localparam int        FRAME_W     = $clog2(WALK_FRAMES + 3)
) (
    input logic               Clk,
    input logic               Reset,
    sprite_anim_seq_if.slave  bus
);
    localparam int PW = WALK_FRAMES > 1 ? $clog2(WALK_FRAMES) : 1;
    localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
    localparam int SW = SKID_TICKS > 1 ? $clog2(SKID_TICKS) : 1;
    typedef enum logic [1:0] {STAND, WALK, SKID, JUMP} state_t;
    state_t        state;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    logic [HW-1:0] hold;
    logic [SW-1:0] skid;
    logic          key_l;
    logic          key_r;
    logic          dir_valid;
    logic          dir_left;
    assign key_l     = (bus.keycode == KEY_LEFT) | (bus.keycode2 == KEY_LEFT);
    assign key_r     = (bus.keycode == KEY_RIGHT) | (bus.keycode2 == KEY_RIGHT);
    assign dir_valid = key_l ^ key_r;
    assign dir_left  = key_l & ~key_r;
    assign phase_nx  = (phase == PW'(WALK_FRAMES - 1)) ? '0 : phase + 1'b1;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= STAND;
            phase           <= '0;
            hold            <= '0;
            skid            <= '0;
            bus.frame_idx   <= '0;
            bus.facing_left <= 1'b0;
            bus.step_pulse  <= 1'b0;
        end else begin
            bus.step_pulse <= 1'b0;
            if (bus.frame_tick) begin
                if (bus.airborne) begin
                    state         <= JUMP;
                    bus.frame_idx <= FRAME_W'(WALK_FRAMES + 2);
                    if (dir_valid) bus.facing_left <= dir_left;
                end else begin
                    case (state)
                        STAND, JUMP: begin
                            state         <= dir_valid ? WALK : STAND;
                            phase         <= '0;
                            hold          <= '0;
                            bus.frame_idx <= dir_valid ? FRAME_W'(1) : '0;
                            if (dir_valid) bus.facing_left <= dir_left;
                        end
                        WALK: begin
                            if (!dir_valid) begin
                                state         <= STAND;
                                phase         <= '0;
                                hold          <= '0;
                                bus.frame_idx <= '0;
                            end else if (dir_left != bus.facing_left) begin
                                state           <= SKID;
                                skid            <= '0;
                                bus.facing_left <= dir_left;
                                bus.frame_idx   <= FRAME_W'(WALK_FRAMES + 1);
                            end else if (hold == HW'(HOLD_TICKS - 1)) begin
                                hold           <= '0;
                                phase          <= phase_nx;
                                bus.frame_idx  <= FRAME_W'(phase_nx) + FRAME_W'(1);
                                bus.step_pulse <= (phase_nx == '0);
                            end else begin
                                hold <= hold + 1'b1;
                            end
                        end
                        SKID: begin
                            if (skid == SW'(SKID_TICKS - 1)) begin
                                // a reversal pending at exit falls back to STAND rather than chaining skids
                                state         <= (dir_valid && dir_left == bus.facing_left) ? WALK : STAND;
                                phase         <= '0;
                                hold          <= '0;
                                skid          <= '0;
                                bus.frame_idx <= (dir_valid && dir_left == bus.facing_left) ? FRAME_W'(1) : '0;
                            end else begin
                                skid <= skid + 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_anim_seq.sv
// tb_sprite_anim_seq: directed checks of walk cycle, skid, jump, tick gating and reset.
module tb_sprite_anim_seq;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;
    sprite_anim_seq_if #(.WALK_FRAMES(3)) bus ();
    sprite_anim_seq dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
    endtask
    task automatic do_reset();
        bus.keycode  = 8'h00;
        bus.keycode2 = 8'h00;
        bus.airborne = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask
    task automatic check_out(input string tag, input int idx, input logic face, input logic stp);
        total += 3;
        assert (bus.frame_idx === 3'(idx)) else begin
            bad++;
            $error("FAIL %s frame_idx observed=%0d expected=%0d", tag, bus.frame_idx, idx);
        end
        assert (bus.facing_left === face) else begin
            bad++;
            $error("FAIL %s facing_left observed=%0b expected=%0b", tag, bus.facing_left, face);
        end
        assert (bus.step_pulse === stp) else begin
            bad++;
            $error("FAIL %s step_pulse observed=%0b expected=%0b", tag, bus.step_pulse, stp);
        end
    endtask
    initial begin
        total = 0;
        bad = 0;
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.keycode = 8'h00;
        bus.keycode2 = 8'h00;
        bus.airborne = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check_out("reset", 0, 1'b0, 1'b0);
        // walk right: 4 ticks per frame, wrap to frame 1 on tick 13
        bus.keycode = 8'h07;
        for (int t = 1; t <= 13; t++) begin
            tick();
            check_out($sformatf("walk_r_t%0d", t), (t == 13) ? 1 : (t - 1) / 4 + 1, 1'b0, logic'(t == 13));
        end
        @(negedge Clk);
        check_out("step_drop", 1, 1'b0, 1'b0);
        // reversal skid to the left, then walk left
        do_reset();
        bus.keycode = 8'h07;
        repeat (5) tick();
        check_out("pre_skid", 2, 1'b0, 1'b0);
        bus.keycode = 8'h04;
        for (int t = 0; t < 6; t++) begin
            tick();
            check_out($sformatf("skid_l_t%0d", t), 4, 1'b1, 1'b0);
        end
        tick();
        check_out("skid_exit_walk", 1, 1'b1, 1'b0);
        // reverse again, release keys mid-skid: full-length skid, exit to stand
        bus.keycode = 8'h07;
        for (int t = 0; t < 6; t++) begin
            tick();
            check_out($sformatf("skid_r_t%0d", t), 4, 1'b0, 1'b0);
            if (t == 1) bus.keycode = 8'h00;
        end
        tick();
        check_out("skid_exit_stand", 0, 1'b0, 1'b0);
        // both directions held: no movement, facing kept at left
        bus.keycode = 8'h04;
        tick();
        check_out("walk_l", 1, 1'b1, 1'b0);
        bus.keycode = 8'h00;
        tick();
        check_out("stand_l", 0, 1'b1, 1'b0);
        bus.keycode = 8'h04;
        bus.keycode2 = 8'h07;
        for (int t = 0; t < 10; t++) begin
            tick();
            check_out($sformatf("both_t%0d", t), 0, 1'b1, 1'b0);
        end
        bus.keycode2 = 8'h00;
        // jump mid-walk with left held, land with no keys
        bus.keycode = 8'h07;
        repeat (3) tick();
        check_out("pre_jump", 1, 1'b0, 1'b0);
        bus.keycode = 8'h04;
        bus.airborne = 1'b1;
        tick();
        check_out("jump", 5, 1'b1, 1'b0);
        bus.airborne = 1'b0;
        bus.keycode = 8'h00;
        tick();
        check_out("land", 0, 1'b1, 1'b0);
        // no frame_tick: keys are invisible
        do_reset();
        bus.keycode = 8'h07;
        repeat (200) @(negedge Clk);
        check_out("no_tick", 0, 1'b0, 1'b0);
        tick();
        check_out("one_tick", 1, 1'b0, 1'b0);
        // reset wins over frame_tick mid-skid
        bus.keycode = 8'h04;
        tick();
        check_out("skid_pre_reset", 4, 1'b1, 1'b0);
        Reset = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        check_out("reset_skid", 0, 1'b0, 1'b0);
        Reset = 1'b0;
        bus.frame_tick = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
